// File: rtl/demux_stream_n_if.sv
// Handshake bundle for demux_stream_n: one producer-side stream, N consumer
// slots, the registered one-hot of the last routed select and the drop pulse.
interface demux_stream_n_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned DW   = 8,
  parameter int unsigned SELW = $clog2(N)
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [SELW-1:0] in_sel;
  logic            in_bcast;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    last_onehot;
  logic            err_drop;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, last_onehot, err_drop
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, last_onehot, err_drop
  );
endinterface

// File: rtl/demux_stream_n.sv
// Registered 1-to-N valid/ready stream demultiplexer with one-entry slots per channel.
// Optional broadcast to every slot is compiled in with `define DEMUX_BROADCAST_EN.
module demux_stream_n #(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  demux_stream_n_if.slave bus
);
  logic [N-1:0]    r_v;
  logic [DW-1:0]   r_d [N];
  logic [N-1:0]    r_last;
  logic            r_err;

  logic [N-1:0]    w_dec;
  logic            w_sel_ok;
  logic [N-1:0]    w_can_take;
  logic            w_bc;
  logic            w_ready;
  logic            w_accept;
  logic            w_drop;
  logic [N-1:0]    w_wr;
  logic [N*DW-1:0] w_out_data;

  // Decoding by comparison keeps out-of-range selects (N not a power of two) all-zero.
  always_comb begin
    w_dec = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_dec[k] = (32'(bus.in_sel) == k);
    end
  end

  assign w_sel_ok   = |w_dec;
  assign w_can_take = ~r_v | bus.out_ready;

`ifdef DEMUX_BROADCAST_EN
  assign w_bc = bus.in_bcast;
`else
  logic w_unused_bcast;
  assign w_bc           = 1'b0;
  assign w_unused_bcast = bus.in_bcast;
`endif

  always_comb begin
    if (w_bc) begin
      w_ready = &w_can_take;
    end else begin
      w_ready = ~w_sel_ok | (|(w_dec & w_can_take));
    end
    w_accept = bus.in_valid & w_ready;
    w_wr     = '0;
    w_drop   = 1'b0;
    if (w_accept) begin
      if (w_bc) begin
        w_wr = '1;
      end else if (w_sel_ok) begin
        w_wr = w_dec;
      end else begin
        w_drop = 1'b1;
      end
    end
  end

  // A write wins over a drain on the same channel, so a full slot streams at one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_last <= '0;
      r_err  <= 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        r_d[k] <= '0;
      end
    end else begin
      r_err <= w_drop;
      if (w_accept && !w_drop) begin
        r_last <= w_bc ? '1 : w_dec;
      end
      for (int unsigned k = 0; k < N; k++) begin
        if (w_wr[k]) begin
          r_v[k] <= 1'b1;
          r_d[k] <= bus.in_data;
        end else if (r_v[k] && bus.out_ready[k]) begin
          r_v[k] <= 1'b0;
          r_d[k] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_out_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (r_v[k]) begin
        w_out_data[k*DW +: DW] = r_d[k];
      end
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.out_valid   = r_v;
  assign bus.out_data    = w_out_data;
  assign bus.last_onehot = r_last;
  assign bus.err_drop    = r_err;
endmodule

// File: tb/tb_demux_stream_n.sv
// Bench for demux_stream_n: an 8-channel and a 6-channel instance share one
// directed stimulus stream and are checked every cycle against a slot-level model.
module tb_demux_stream_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_valid = 1'b0;
  logic [2:0] s_sel   = '0;
  logic [7:0] s_data  = '0;
  logic       s_bc    = 1'b0;
  logic [7:0] s_ordy  = '0;

  int total = 0;
  int bad   = 0;

  demux_stream_n_if #(.N(8), .DW(8)) ifa ();
  demux_stream_n_if #(.N(6), .DW(8)) ifb ();

  assign ifa.in_valid  = s_valid;
  assign ifa.in_sel    = s_sel;
  assign ifa.in_data   = s_data;
  assign ifa.in_bcast  = s_bc;
  assign ifa.out_ready = s_ordy;
  assign ifb.in_valid  = s_valid;
  assign ifb.in_sel    = s_sel;
  assign ifb.in_data   = s_data;
  assign ifb.in_bcast  = s_bc;
  assign ifb.out_ready = s_ordy[5:0];

  demux_stream_n #(.N(8), .DW(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  demux_stream_n #(.N(6), .DW(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  typedef struct packed {
    logic [7:0]  v;
    logic [63:0] d;
    logic [7:0]  lo;
    logic        err;
  } mstate_t;

  mstate_t ma, mb;

  function automatic logic mready(int n, mstate_t s, logic [2:0] sel, logic bc, logic [7:0] ordy);
    logic r;
    r = 1'b1;
`ifdef DEMUX_BROADCAST_EN
    if (bc) begin
      for (int k = 0; k < n; k++) if (s.v[k] && !ordy[k]) r = 1'b0;
      return r;
    end
`endif
    if (int'(sel) >= n) return 1'b1;
    r = !s.v[sel] || ordy[sel];
    return r;
  endfunction

  function automatic mstate_t mstep(int n, mstate_t s, logic vld, logic [2:0] sel, logic bc,
                                    logic [7:0] data, logic [7:0] ordy);
    mstate_t t;
    logic    rdy;
    logic    use_bc;
    t      = s;
    t.err  = 1'b0;
    rdy    = mready(n, s, sel, bc, ordy);
    use_bc = 1'b0;
`ifdef DEMUX_BROADCAST_EN
    use_bc = bc;
`endif
    for (int k = 0; k < n; k++) begin
      if (s.v[k] && ordy[k]) begin
        t.v[k] = 1'b0;
        t.d[k*8 +: 8] = 8'h00;
      end
    end
    if (vld && rdy) begin
      if (use_bc) begin
        for (int k = 0; k < n; k++) begin
          t.v[k] = 1'b1;
          t.d[k*8 +: 8] = data;
        end
        t.lo = 8'((9'd1 << n) - 9'd1);
      end else if (int'(sel) >= n) begin
        t.err = 1'b1;
      end else begin
        t.v[sel] = 1'b1;
        t.d[int'(sel)*8 +: 8] = data;
        t.lo = 8'(1) << sel;
      end
    end
    return t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mstep(8, ma, s_valid, s_sel, s_bc, s_data, s_ordy);
      mb <= mstep(6, mb, s_valid, s_sel, s_bc, s_data, s_ordy);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_ready", 64'(ifa.in_ready), 64'(mready(8, ma, s_sel, s_bc, s_ordy)));
    chk("a_valid", 64'(ifa.out_valid), 64'(ma.v));
    chk("a_data",  ifa.out_data, ma.d);
    chk("a_last",  64'(ifa.last_onehot), 64'(ma.lo));
    chk("a_err",   64'(ifa.err_drop), 64'(ma.err));
    chk("b_ready", 64'(ifb.in_ready), 64'(mready(6, mb, s_sel, s_bc, s_ordy)));
    chk("b_valid", 64'(ifb.out_valid), 64'(mb.v));
    chk("b_data",  64'(ifb.out_data), mb.d);
    chk("b_last",  64'(ifb.last_onehot), 64'(mb.lo));
    chk("b_err",   64'(ifb.err_drop), 64'(mb.err));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'($urandom);
      s_sel   = 3'($urandom);
      s_data  = 8'($urandom);
      s_bc    = 1'($urandom);
      s_ordy  = 8'($urandom);
      cyc();
    end
    chk("rst_valid", 64'(ifa.out_valid), 64'h0);
    chk("rst_data",  ifa.out_data, 64'h0);
    chk("rst_last",  64'(ifa.last_onehot), 64'h0);
    chk("rst_ready", 64'(ifa.in_ready), 64'h1);
    s_valid = 1'b0; s_bc = 1'b0; s_ordy = 8'h00;
    rst_n = 1'b1;
    cyc();

    // First word to channel 3
    s_valid = 1'b1; s_sel = 3'd3; s_data = 8'hA5;
    cyc();
    s_valid = 1'b0;
    chk("first_valid", 64'(ifa.out_valid), 64'h08);
    chk("first_data3", 64'(ifa.out_data[31:24]), 64'hA5);
    chk("first_last",  64'(ifa.last_onehot), 64'h08);
    chk("first_b_valid", 64'(ifb.out_valid), 64'h08);

    // Backpressure on channel 5
    s_valid = 1'b1; s_sel = 3'd5; s_data = 8'h55;
    cyc();
    s_data = 8'h56;
    #1;
    chk("bp_ready5", 64'(ifa.in_ready), 64'h0);
    cyc();
    chk("bp_held5", 64'(ifa.out_data[47:40]), 64'h55);
    s_sel = 3'd2; s_data = 8'h22;
    #1;
    chk("bp_ready2", 64'(ifa.in_ready), 64'h1);
    cyc();
    s_valid = 1'b0;
    chk("bp_valid", 64'(ifa.out_valid), 64'h2C);

    // Drain everything
    s_ordy = 8'hFF;
    cyc();
    s_ordy = 8'h00;
    chk("drain_valid", 64'(ifa.out_valid), 64'h00);
    chk("drain_data",  ifa.out_data, 64'h0);

    // Simultaneous drain and write on channel 1
    s_valid = 1'b1; s_sel = 3'd1; s_data = 8'h11;
    cyc();
    s_ordy = 8'h02; s_data = 8'h22;
    #1;
    chk("dw_ready", 64'(ifa.in_ready), 64'h1);
    cyc();
    chk("dw_valid", 64'(ifa.out_valid), 64'h02);
    chk("dw_data1", 64'(ifa.out_data[15:8]), 64'h22);

    // Back-to-back stream into channel 1
    cnt = 0;
    s_ordy = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      s_data = 8'h30 + 8'(i);
      #1;
      if (ifa.in_ready) cnt++;
      cyc();
    end
    s_valid = 1'b0; s_ordy = 8'h00;
    chk("throughput", 64'(cnt), 64'd8);
    chk("stream_last1", 64'(ifa.out_data[15:8]), 64'h37);

    // Out-of-range select on the 6-channel instance
    s_valid = 1'b1; s_sel = 3'd7; s_data = 8'h77;
    #1;
    chk("oor_ready", 64'(ifb.in_ready), 64'h1);
    cyc();
    s_valid = 1'b0;
    chk("oor_err",   64'(ifb.err_drop), 64'h1);
    chk("oor_valid", 64'(ifb.out_valid), 64'h02);
    chk("oor_last",  64'(ifb.last_onehot), 64'h02);
    chk("a_sel7_valid", 64'(ifa.out_valid), 64'h82);
    cyc();
    chk("oor_err_pulse", 64'(ifb.err_drop), 64'h0);
    s_valid = 1'b1; s_sel = 3'd6;
    cyc();
    s_valid = 1'b0;
    chk("oor6_err", 64'(ifb.err_drop), 64'h1);

    // Broadcast request
    s_ordy = 8'hFF;
    cyc();
    s_ordy = 8'h00;
    s_valid = 1'b1; s_bc = 1'b1; s_sel = 3'd4; s_data = 8'h3C;
    cyc();
    s_valid = 1'b0;
`ifdef DEMUX_BROADCAST_EN
    chk("bc_valid", 64'(ifa.out_valid), 64'hFF);
    chk("bc_data",  ifa.out_data, {8{8'h3C}});
    chk("bc_last",  64'(ifa.last_onehot), 64'hFF);
    chk("bc_b_valid", 64'(ifb.out_valid), 64'h3F);
    chk("bc_b_last",  64'(ifb.last_onehot), 64'h3F);
    s_valid = 1'b1; s_ordy = 8'hFE;
    #1;
    chk("bc_blocked", 64'(ifa.in_ready), 64'h0);
    cyc();
    s_valid = 1'b0;
`else
    chk("nobc_valid", 64'(ifa.out_valid), 64'h10);
    chk("nobc_last",  64'(ifa.last_onehot), 64'h10);
    chk("nobc_data4", 64'(ifa.out_data[39:32]), 64'h3C);
`endif
    s_bc = 1'b0;
    s_ordy = 8'hFF;
    cyc();
    s_ordy = 8'h00;

    // Fill three slots, then assert reset between edges
    s_valid = 1'b1; s_sel = 3'd0; s_data = 8'hC0;
    cyc();
    s_sel = 3'd4; s_data = 8'hC4;
    cyc();
    s_sel = 3'd2; s_data = 8'hC2;
    cyc();
    s_valid = 1'b0;
    chk("pre_rst_valid", 64'(ifa.out_valid), 64'h15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid_a", 64'(ifa.out_valid), 64'h0);
    chk("async_valid_b", 64'(ifb.out_valid), 64'h0);
    chk("async_data_a",  ifa.out_data, 64'h0);
    chk("async_last_a",  64'(ifa.last_onehot), 64'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    s_valid = 1'b1; s_sel = 3'd6; s_data = 8'h66;
    cyc();
    s_valid = 1'b0;
    chk("post_rst_valid", 64'(ifa.out_valid), 64'h40);
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux_stream_n.md
# demux_stream_n

Parametrised, registered 1-to-N stream demultiplexer with a valid/ready handshake on the input and on every output channel. An input word is routed to the output slot chosen by its select value. This is the N-channel, handshaked successor of the fixed 3-to-8 demux/decoder. The block sits between a single producer and N independent consumers, and also exports a registered one-hot decode of the last routed select.

## Interface
Parameters:
- N, default 8: number of output channels, 2..256; need not be a power of two.
- DW, default 8: data width per word.
- SELW, default $clog2(N): select width, derived; never overridden.

Ports:
- clk  in  1  single clock; all registers update on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  DW  payload.
- in_sel  in  SELW  destination channel index.
- in_bcast  in  1  broadcast request; honoured only with DEMUX_BROADCAST_EN.
- out_valid  out  N  per-channel slot full.
- out_ready  in  N  per-channel consumer ready.
- out_data  out  N*DW  channel k occupies bits [k*DW +: DW].
- last_onehot  out  N  one-hot of the last accepted in_sel.
- err_drop  out  1  one-cycle pulse when an out-of-range select is dropped.

## Operation
- Each channel k has a one-entry slot: valid bit v[k] and data register d[k]. out_valid[k] = v[k].
- out_data channel k = d[k] when v[k]=1, else all zeros (decoder-style zero default).
- Channel k can take data when v[k]=0 or out_ready[k]=1.
- Unicast (in_bcast=0 or macro absent), in_sel < N:
  - in_ready = v[in_sel]==0 or out_ready[in_sel]==1.
  - On in_valid and in_ready, d[in_sel] <= in_data, v[in_sel] <= 1, last_onehot <= 1<<in_sel.
- Out-of-range select (in_sel >= N, possible only when N is not a power of two):
  - in_ready = 1.
  - On in_valid, the word is discarded, err_drop pulses for 1 cycle, and last_onehot is unchanged.
- Output drain: out_valid[k] and out_ready[k] high with no write to k in that cycle gives v[k] <= 0 and d[k] <= 0.
- Drain and write to the same channel in one cycle: v[k] stays 1 and d[k] takes the new word. This gives full throughput of 1 word/cycle per channel.
- Channels are independent. A stalled channel blocks the input only while in_sel points at it; there is no head-of-line buffering beyond the single input word.
- in_ready is combinational from in_sel, in_bcast, v and out_ready. There is no combinational path from in_valid to in_ready.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - out_valid = 0, all d[k] = 0 (so out_data = 0).
  - last_onehot = 0, err_drop = 0.
  - in_ready reflects empty slots: 1 after reset.
- Reset deasserts synchronously into the design; the first accept is possible on the first rising edge with rst_n high.
- Latency is 1 cycle: a word accepted at edge t appears on out_data/out_valid after edge t and stays stable until the handshake completes.
- Reset asserted mid-transfer discards all slot contents; no partial state survives.
- err_drop and last_onehot are registered and update on the accepting edge.

## Configuration
- Macro DEMUX_BROADCAST_EN.
- Defined:
  - When in_bcast=1, in_sel is ignored and in_ready = AND over k of (v[k]==0 or out_ready[k]).
  - On accept, every slot loads in_data and sets v[k]=1, and last_onehot <= all ones.
  - Broadcast never asserts err_drop.
- Undefined:
  - in_bcast is ignored (treated as 0) and no broadcast logic is synthesised.
  - The port remains for a stable interface.

## Test plan
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_data=0, last_onehot=0, in_ready=1. Release reset, then send in_sel=3, in_data=0xA5 -> next cycle out_valid=8'b0000_1000, channel 3 data=0xA5, last_onehot=8'h08.
- Backpressure: fill channel 5 with out_ready[5]=0, then present a second word to channel 5 -> in_ready=0 and the word is held. Present a word to channel 2 -> in_ready=1 and it is accepted.
- Simultaneous drain and write: channel 1 full with 0x11 and out_ready[1]=1, present 0x22 to channel 1 -> accepted, out_valid[1] stays 1, data=0x22 next cycle. Drive 8 back-to-back words -> 8 transfers in 8 cycles.
- Out-of-range select: N=6, in_sel=7, in_valid=1 -> in_ready=1, err_drop=1 for one cycle, out_valid unchanged, last_onehot unchanged.
- Broadcast (macro defined): in_bcast=1, in_data=0x3C with all slots empty -> all out_valid=1, every channel=0x3C, last_onehot=all ones. Repeat with channel 0 full and out_ready[0]=0 -> in_ready=0.
- Async reset mid-operation: assert rst_n between clock edges with 3 slots full -> out_valid drops to 0 immediately, without waiting for a clock edge.
